// File: rtl/ecpeta_pkg.sv
// Shared types and helpers for the ECPETA approximate-adder arbiter:
// FSM encodings, the ECPETA sum function and the round-robin search.
package ecpeta_pkg;

    localparam int unsigned MAXW    = 64;
    localparam int unsigned RR_MAXN = 32;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    // ECPETA sum of n-bit operands (zero-extended to MAXW); k is the exact upper width
    function automatic logic [MAXW-1:0] ecpeta_sum(input logic [MAXW-1:0] a,
                                                   input logic [MAXW-1:0] b,
                                                   input int unsigned     n,
                                                   input int unsigned     k);
        logic [MAXW-1:0] o;
        logic [MAXW-1:0] g;
        logic [MAXW-1:0] s;
        logic [MAXW-1:0] hi;
        logic [MAXW-1:0] n_mask;
        logic            cin;
        logic            t;
        int              l;
        l   = int'(n) - int'(k);
        o   = a | b;
        g   = a & b;
        s   = '0;
        cin = g[6'(l-1)] | g[6'(l-2)];
        s[6'(l-1)] = o[6'(l-1)] & ~cin;
        s[6'(l-2)] = o[6'(l-2)];
        s[6'(l-3)] = o[6'(l-3)] | g[6'(l-2)];
        t = g[6'(l-2)] | g[6'(l-3)];
        // Sticky propagate chain: once any generate is seen, all lower bits saturate
        for (int i = int'(MAXW) - 1; i >= 1; i--) begin
            if (i <= l - 4) begin
                s[6'(i)] = o[6'(i)] | t;
                t        = t | g[6'(i)];
            end
        end
        s[0]   = o[0] | t;
        hi     = ((a >> l) + (b >> l) + MAXW'(cin)) << l;
        n_mask = (n >= MAXW) ? '1 : ((MAXW'(1) << n) - MAXW'(1));
        return (hi | s) & n_mask;
    endfunction

    // Returns {found, index}: first valid at or after ptr, wrapping modulo nreq
    function automatic logic [5:0] rr_next(input logic [4:0]         ptr,
                                           input logic [RR_MAXN-1:0] valid,
                                           input int unsigned        nreq);
        logic       found;
        logic [4:0] idx;
        int         j;
        found = 1'b0;
        idx   = '0;
        for (int unsigned off = 0; off < RR_MAXN; off++) begin
            j = int'(ptr) + int'(off);
            if (j >= int'(nreq)) j = j - int'(nreq);
            if ((off < nreq) && !found && valid[5'(j)]) begin
                found = 1'b1;
                idx   = 5'(j);
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/ecpeta_core.sv
// Combinational ECPETA approximate adder: approximate lower N-K bits,
// exact ripple-carry upper K bits with a predicted carry-in.
module ecpeta_core
    import ecpeta_pkg::*;
#(
    parameter int unsigned N = 16,
    parameter int unsigned K = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s_c
);

    assign s_c = N'(ecpeta_sum(MAXW'(a), MAXW'(b), N, K));

endmodule

// File: rtl/ecpeta_arbiter.sv
// Round-robin arbiter sharing one ECPETA adder among NREQ requesters, with a
// registered result stage. Define ECPETA_ERR_MON_EN to add the error monitor.
module ecpeta_arbiter
    import ecpeta_pkg::*;
#(
    parameter int unsigned N    = 16,
    parameter int unsigned K    = 8,
    parameter int unsigned NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*N-1:0]       req_a,
    input  logic [NREQ*N-1:0]       req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [N-1:0]            rsp_sum,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic                    busy
`ifdef ECPETA_ERR_MON_EN
    ,
    input  logic                    err_clr,
    output logic [31:0]             err_cnt,
    output logic [N-1:0]            err_max,
    output logic [N-1:0]            rsp_err
`endif
);

    localparam int unsigned IDW = $clog2(NREQ);

    logic            state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [N-1:0]    rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;

    logic            free_c;
    logic            found_c;
    logic            accept_c;
    logic [5:0]      rr_c;
    logic [IDW-1:0]  grant_id_c;
    logic [N-1:0]    a_sel_c, b_sel_c, approx_c;
    logic [NREQ-1:0] req_ready_c;

    assign free_c     = (state_q == ST_EMPTY) | rsp_ready;
    assign rr_c       = rr_next(5'(ptr_q), RR_MAXN'(req_valid), NREQ);
    assign found_c    = rr_c[5];
    assign grant_id_c = IDW'(rr_c[4:0]);
    assign accept_c   = free_c & found_c;

    // Operand mux and one-hot grant
    always_comb begin
        a_sel_c     = '0;
        b_sel_c     = '0;
        req_ready_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_id_c == IDW'(i)) begin
                a_sel_c        = req_a[i*N +: N];
                b_sel_c        = req_b[i*N +: N];
                req_ready_c[i] = accept_c;
            end
        end
    end

    ecpeta_core #(.N(N), .K(K)) u_core (
        .a   (a_sel_c),
        .b   (b_sel_c),
        .s_c (approx_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept_c) state_d = ST_FULL;
            ST_FULL:  if (rsp_ready) state_d = accept_c ? ST_FULL : ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Datapath next values
    always_comb begin
        ptr_d     = ptr_q;
        rsp_sum_d = rsp_sum_q;
        rsp_id_d  = rsp_id_q;
        if (accept_c) begin
            rsp_sum_d = approx_c;
            rsp_id_d  = grant_id_c;
            ptr_d     = (grant_id_c == IDW'(NREQ - 1)) ? '0 : grant_id_c + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            rsp_sum_q <= '0;
            rsp_id_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            rsp_sum_q <= rsp_sum_d;
            rsp_id_q  <= rsp_id_d;
        end
    end

    assign req_ready = req_ready_c;
    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = rsp_valid | (|req_valid);

`ifdef ECPETA_ERR_MON_EN
    logic [N-1:0]  exact_c, diff_c;
    logic [31:0]   err_cnt_q, err_cnt_d;
    logic [N-1:0]  err_max_q, err_max_d;
    logic [N-1:0]  rsp_err_q, rsp_err_d;

    assign exact_c = a_sel_c + b_sel_c;
    assign diff_c  = (exact_c >= approx_c) ? exact_c - approx_c : approx_c - exact_c;

    // Clear takes priority over a coincident accept
    always_comb begin
        err_cnt_d = err_cnt_q;
        err_max_d = err_max_q;
        rsp_err_d = rsp_err_q;
        if (accept_c) rsp_err_d = diff_c;
        if (err_clr) begin
            err_cnt_d = '0;
            err_max_d = '0;
        end else if (accept_c) begin
            if ((diff_c != '0) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 32'd1;
            if (diff_c > err_max_q) err_max_d = diff_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
            err_max_q <= '0;
            rsp_err_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            err_max_q <= err_max_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign err_cnt = err_cnt_q;
    assign err_max = err_max_q;
    assign rsp_err = rsp_err_q;
`endif

endmodule

// File: tb/tb_ecpeta_arbiter.sv
// Directed self-checking bench for ecpeta_arbiter (N=16, K=8, NREQ=4);
// also covers the ECPETA_ERR_MON_EN outputs when that macro is defined.
module tb_ecpeta_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_sum;
    logic [1:0]  rsp_id;
    logic        busy;
`ifdef ECPETA_ERR_MON_EN
    logic        err_clr;
    logic [31:0] err_cnt;
    logic [15:0] err_max;
    logic [15:0] rsp_err;
`endif

    int errors = 0;
    int checks = 0;

    ecpeta_arbiter #(.N(16), .K(8), .NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .busy      (busy)
`ifdef ECPETA_ERR_MON_EN
        ,
        .err_clr   (err_clr),
        .err_cnt   (err_cnt),
        .err_max   (err_max),
        .rsp_err   (rsp_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
    endtask

    initial begin
        logic [3:0]  exp_rdy;
        logic [15:0] exp_sum;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
`ifdef ECPETA_ERR_MON_EN
        err_clr   = 1'b0;
`endif
        #3;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_sum",   64'(rsp_sum),   64'd0);
        chk("reset_rsp_id",    64'(rsp_id),    64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_busy",      64'(busy),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single request from requester 1
        set_op(1, 16'h0003, 16'h0001);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        #1;
        chk("single_req_ready", 64'(req_ready), 64'h2);
        chk("single_busy",      64'(busy),      64'd1);
        tick();
        req_valid = '0;
        #1;
        chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("single_rsp_sum",   64'(rsp_sum),   64'h0003);
        chk("single_rsp_id",    64'(rsp_id),    64'd1);
        chk("single_ready_off", 64'(req_ready), 64'd0);
`ifdef ECPETA_ERR_MON_EN
        chk("single_rsp_err",   64'(rsp_err),   64'd1);
        chk("single_err_cnt",   64'(err_cnt),   64'd1);
`endif

        // Carry prediction from requester 2 (pointer now 2)
        set_op(2, 16'h00C0, 16'h00C0);
        req_valid = 4'b0100;
        #1;
        chk("carry_req_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        #1;
        chk("carry_rsp_sum", 64'(rsp_sum), 64'h017F);
        chk("carry_rsp_id",  64'(rsp_id),  64'd2);
`ifdef ECPETA_ERR_MON_EN
        chk("carry_rsp_err", 64'(rsp_err), 64'd1);
        chk("carry_err_cnt", 64'(err_cnt), 64'd2);
        chk("carry_err_max", 64'(err_max), 64'd1);
`endif

        // Exact upper path: carry-out dropped, then an exact sum
        set_op(3, 16'hFF00, 16'h0100);
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        #1;
        chk("upper_wrap_sum", 64'(rsp_sum), 64'h0000);
        chk("upper_wrap_id",  64'(rsp_id),  64'd3);
        set_op(0, 16'h1200, 16'h3400);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        #1;
        chk("upper_add_sum", 64'(rsp_sum), 64'h4600);
        chk("upper_add_id",  64'(rsp_id),  64'd0);
`ifdef ECPETA_ERR_MON_EN
        chk("upper_add_err", 64'(rsp_err), 64'd0);
        chk("upper_err_cnt", 64'(err_cnt), 64'd2);
`endif

        // Drain to EMPTY
        tick();
        chk("drain_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("drain_busy",      64'(busy),      64'd0);

        // With B=0 the approximate sum equals A
        for (int i = 0; i < 4; i++) set_op(i, 16'(16'h1000 * (i + 1) + i), 16'h0000);

        // Backpressure: pointer is 1, consumer stalled
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("bp_first_ready", 64'(req_ready), 64'h2);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_ready", 64'(req_ready), 64'd0);
            chk("bp_hold_sum",   64'(rsp_sum),   64'h2001);
            chk("bp_hold_id",    64'(rsp_id),    64'd1);
            chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_drain_grant", 64'(req_ready), 64'h4);
        tick();
        chk("bp_next_sum",   64'(rsp_sum),   64'h3002);
        chk("bp_next_id",    64'(rsp_id),    64'd2);
        chk("bp_next_valid", 64'(rsp_valid), 64'd1);

        // Asynchronous reset while a result is held
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(rsp_valid), 64'd0);
        chk("rst_mid_sum",   64'(rsp_sum),   64'd0);
        chk("rst_mid_id",    64'(rsp_id),    64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;

        // All requesters valid: grants rotate 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            exp_rdy = 4'b0001 << (k % 4);
            exp_sum = 16'(16'h1000 * ((k % 4) + 1) + (k % 4));
            chk("rr_ready", 64'(req_ready), 64'(exp_rdy));
            tick();
            chk("rr_id",    64'(rsp_id),    64'(k % 4));
            chk("rr_sum",   64'(rsp_sum),   64'(exp_sum));
            chk("rr_valid", 64'(rsp_valid), 64'd1);
        end
        req_valid = '0;

`ifdef ECPETA_ERR_MON_EN
        chk("rr_err_cnt_after_reset", 64'(err_cnt), 64'd0);
        // Clear coinciding with an erroring accept: the clear wins
        set_op(1, 16'h00C0, 16'h00C0);
        req_valid = 4'b0010;
        err_clr   = 1'b1;
        tick();
        err_clr   = 1'b0;
        chk("clr_err_cnt", 64'(err_cnt), 64'd0);
        chk("clr_err_max", 64'(err_max), 64'd0);
        chk("clr_rsp_err", 64'(rsp_err), 64'd1);
        set_op(2, 16'h00C0, 16'h00C0);
        req_valid = 4'b0100;
        tick();
        chk("post_clr_err_cnt", 64'(err_cnt), 64'd1);
        chk("post_clr_err_max", 64'(err_max), 64'd1);
        req_valid = '0;
`endif

        tick();
        tick();
        chk("final_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("final_busy",      64'(busy),      64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
